data_sync_launcher: RTL and testbench

Source-domain launch stage that feeds the data synchronizer. It accepts words on a valid/ready interface and presents them as a level-qualified, glitch-free bus: `sync_data` plus `sync_ready`. It holds `sync_ready` high for a fixed number of source cycles and keeps `sync_data` stable for a guard interval afterwards, so the destination flip-flop chain always samples a settled word. A one-entry pending register gives back-to-back throughput without stalling the producer mid-launch.

---
 rtl/data_sync_pkg.sv | 24 ++
 rtl/data_sync_pend_reg.sv | 43 ++++
 rtl/data_sync_launcher.sv | 127 ++++++++++++
 tb/tb_data_sync_launcher.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/data_sync_pkg.sv
// Shared definitions for the data synchronizer launch stage: state encoding,
// counter sizing helper and default timing constants.
package data_sync_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_HOLD  = 2'b01,
        ST_GUARD = 2'b10
    } state_e;

    localparam int DEF_DWIDTH       = 8;
    localparam int DEF_HOLD_CYCLES  = 8;
    localparam int DEF_GUARD_CYCLES = 8;

    // Down-counter only ever holds (cycles-1), so clog2(max) bits suffice; keep >= 1 bit.
    function automatic int cnt_width(input int hold_cycles, input int guard_cycles);
        int max_cycles;
        int w;
        max_cycles = (hold_cycles > guard_cycles) ? hold_cycles : guard_cycles;
        w = $clog2(max_cycles);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/data_sync_pend_reg.sv
// One-entry holding register with valid bit; clear wins over load.
module data_sync_pend_reg
    import data_sync_pkg::*;
#(
    parameter int DWIDTH = DEF_DWIDTH
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              load,
    input  logic              clear,
    input  logic [DWIDTH-1:0] d,
    output logic              valid,
    output logic [DWIDTH-1:0] q
);

    logic              valid_q, valid_d;
    logic [DWIDTH-1:0] data_q, data_d;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (clear) begin
            valid_d = 1'b0;
        end else if (load) begin
            valid_d = 1'b1;
            data_d  = d;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid = valid_q;
    assign q     = data_q;

endmodule

// File: rtl/data_sync_launcher.sv
// Source-domain launch stage: holds sync_ready for HOLD_CYCLES, then keeps
// sync_data frozen for GUARD_CYCLES before the next word may launch.
module data_sync_launcher
    import data_sync_pkg::*;
#(
    parameter int DWIDTH       = DEF_DWIDTH,
    parameter int HOLD_CYCLES  = DEF_HOLD_CYCLES,
    parameter int GUARD_CYCLES = DEF_GUARD_CYCLES
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [DWIDTH-1:0] s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic [DWIDTH-1:0] sync_data,
    output logic              sync_ready,
    output logic              busy,
    output logic [1:0]        dbg_state
);

    localparam int            CW         = cnt_width(HOLD_CYCLES, GUARD_CYCLES);
    localparam logic [CW-1:0] HOLD_LOAD  = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] GUARD_LOAD = CW'(GUARD_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE    = CW'(1);

    // Handshake: a word moves when s_valid && s_ready at a rising edge;
    // s_ready depends only on the pending register, never on s_valid.
    state_e            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [DWIDTH-1:0] sync_data_q, sync_data_d;
    logic              sync_ready_q, sync_ready_d;

    logic              accept;
    logic              pend_load, pend_clear, pend_valid;
    logic [DWIDTH-1:0] pend_data;

    data_sync_pend_reg #(.DWIDTH(DWIDTH)) u_pend (
        .clk   (clk),
        .rstn  (rstn),
        .load  (pend_load),
        .clear (pend_clear),
        .d     (s_data),
        .valid (pend_valid),
        .q     (pend_data)
    );

    assign accept = s_valid && s_ready;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            sync_data_q  <= '0;
            sync_ready_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            sync_data_q  <= sync_data_d;
            sync_ready_q <= sync_ready_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        sync_data_d  = sync_data_q;
        sync_ready_d = sync_ready_q;
        pend_load    = 1'b0;
        pend_clear   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d      = ST_HOLD;
                    sync_data_d  = s_data;
                    sync_ready_d = 1'b1;
                    cnt_d        = HOLD_LOAD;
                end
            end
            ST_HOLD: begin
                pend_load = accept;
                if (cnt_q == '0) begin
                    state_d      = ST_GUARD;
                    sync_ready_d = 1'b0;
                    cnt_d        = GUARD_LOAD;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            ST_GUARD: begin
                if (cnt_q == '0) begin
                    // A word arriving on the last guard cycle bypasses the pending register.
                    if (pend_valid) begin
                        state_d      = ST_HOLD;
                        sync_data_d  = pend_data;
                        sync_ready_d = 1'b1;
                        cnt_d        = HOLD_LOAD;
                        pend_clear   = 1'b1;
                    end else if (accept) begin
                        state_d      = ST_HOLD;
                        sync_data_d  = s_data;
                        sync_ready_d = 1'b1;
                        cnt_d        = HOLD_LOAD;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    pend_load = accept;
                    cnt_d     = cnt_q - CNT_ONE;
                end
            end
            default: begin
                state_d      = ST_IDLE;
                sync_ready_d = 1'b0;
                cnt_d        = '0;
            end
        endcase
    end

    always_comb begin
        s_ready    = ~pend_valid;
        busy       = (state_q != ST_IDLE) || pend_valid;
        sync_data  = sync_data_q;
        sync_ready = sync_ready_q;
        dbg_state  = state_q;
    end

endmodule

// File: tb/tb_data_sync_launcher.sv
// Directed bench for data_sync_launcher plus an end-to-end run through a
// two-stage destination-domain synchronizer model on a slower clock.
module tb_data_sync_launcher;
    import data_sync_pkg::*;

    logic       clk = 1'b0;
    logic       dclk = 1'b0;
    logic       rstn;
    logic [7:0] s_data;
    logic       s_valid;
    logic       s_ready;
    logic [7:0] sync_data;
    logic       sync_ready;
    logic       busy;
    logic [1:0] dbg_state;

    logic [7:0] e_s_data;
    logic       e_s_valid;
    logic       e_s_ready;
    logic [7:0] e_sync_data;
    logic       e_sync_ready;
    logic       e_busy;
    logic [1:0] e_dbg_state;

    int n_checks = 0;
    int n_fail   = 0;
    int n_recv   = 0;
    logic [7:0] exp_q[$];

    logic d_r1 = 1'b0, d_r2 = 1'b0, d_r3 = 1'b0;
    logic [7:0] dout;

    data_sync_launcher #(.DWIDTH(8), .HOLD_CYCLES(4), .GUARD_CYCLES(3)) u_dut (
        .clk        (clk),
        .rstn       (rstn),
        .s_data     (s_data),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .sync_data  (sync_data),
        .sync_ready (sync_ready),
        .busy       (busy),
        .dbg_state  (dbg_state)
    );

    // Destination period 17 vs source 10; (STAGES+2)*17 = 68 ns needs HOLD >= 7.
    data_sync_launcher #(.DWIDTH(8), .HOLD_CYCLES(8), .GUARD_CYCLES(8)) u_e2e (
        .clk        (clk),
        .rstn       (rstn),
        .s_data     (e_s_data),
        .s_valid    (e_s_valid),
        .s_ready    (e_s_ready),
        .sync_data  (e_sync_data),
        .sync_ready (e_sync_ready),
        .busy       (e_busy),
        .dbg_state  (e_dbg_state)
    );

    // clock/reset block
    initial forever #5 clk = ~clk;
    initial forever begin
        #8 dclk = 1'b1;
        #9 dclk = 1'b0;
    end
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Destination synchronizer model: 2-flop qualifier chain, capture on its rising edge.
    always @(posedge dclk) begin
        d_r1 <= e_sync_ready;
        d_r2 <= d_r1;
        d_r3 <= d_r2;
        if (d_r2 && !d_r3) begin
            dout = e_sync_data;
            n_recv++;
            if (exp_q.size() == 0) begin
                check("e2e_unexpected_word", 32'(dout), 32'hFFFF_FFFF);
            end else begin
                check("e2e_dout", 32'(dout), 32'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        bit got;
        rstn      = 1'b0;
        s_valid   = 1'b0;
        s_data    = 8'h00;
        e_s_valid = 1'b0;
        e_s_data  = 8'h00;
        #1;
        check("rst_sync_ready", 32'(sync_ready), 0);
        check("rst_sync_data", 32'(sync_data), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_s_ready", 32'(s_ready), 1);
        #20 rstn = 1'b1;
        tick();

        // Single word, HOLD=4 GUARD=3
        s_data = 8'hA5; s_valid = 1'b1;
        tick();
        s_valid = 1'b0;
        check("single_ready_e0", 32'(sync_ready), 1);
        check("single_data_e0", 32'(sync_data), 32'hA5);
        check("single_busy_e0", 32'(busy), 1);
        check("single_s_ready_e0", 32'(s_ready), 1);
        for (int i = 1; i <= 6; i++) begin
            tick();
            check("single_ready", 32'(sync_ready), (i <= 3) ? 1 : 0);
            check("single_data", 32'(sync_data), 32'hA5);
            check("single_s_ready", 32'(s_ready), 1);
            check("single_busy", 32'(busy), 1);
        end
        tick();
        check("single_idle_state", 32'(dbg_state), 32'(ST_IDLE));
        check("single_idle_busy", 32'(busy), 0);
        check("single_idle_data", 32'(sync_data), 32'hA5);

        // Back-to-back 0x11, 0x22, 0x33
        s_data = 8'h11; s_valid = 1'b1;
        tick();
        check("b2b_data_e0", 32'(sync_data), 32'h11);
        check("b2b_ready_e0", 32'(sync_ready), 1);
        s_data = 8'h22;
        tick();
        check("b2b_s_ready_e1", 32'(s_ready), 0);
        check("b2b_busy_e1", 32'(busy), 1);
        s_data = 8'h33;
        for (int i = 2; i <= 6; i++) begin
            tick();
            check("b2b_data_11", 32'(sync_data), 32'h11);
            check("b2b_ready_11", 32'(sync_ready), (i <= 3) ? 1 : 0);
            check("b2b_s_ready_full", 32'(s_ready), 0);
            check("b2b_not_idle", 32'(dbg_state != ST_IDLE), 1);
        end
        tick();
        check("b2b_data_e7", 32'(sync_data), 32'h22);
        check("b2b_ready_e7", 32'(sync_ready), 1);
        check("b2b_state_e7", 32'(dbg_state), 32'(ST_HOLD));
        check("b2b_s_ready_e7", 32'(s_ready), 1);
        tick();
        check("b2b_s_ready_e8", 32'(s_ready), 0);
        s_valid = 1'b0;
        for (int i = 9; i <= 13; i++) begin
            tick();
            check("b2b_data_22", 32'(sync_data), 32'h22);
            check("b2b_ready_22", 32'(sync_ready), (i <= 10) ? 1 : 0);
            check("b2b_s_ready_22", 32'(s_ready), 0);
        end
        tick();
        check("b2b_data_e14", 32'(sync_data), 32'h33);
        check("b2b_ready_e14", 32'(sync_ready), 1);
        check("b2b_s_ready_e14", 32'(s_ready), 1);
        for (int i = 15; i <= 20; i++) begin
            tick();
            check("b2b_data_33", 32'(sync_data), 32'h33);
            check("b2b_ready_33", 32'(sync_ready), (i <= 17) ? 1 : 0);
        end
        tick();
        check("b2b_idle_state", 32'(dbg_state), 32'(ST_IDLE));
        check("b2b_idle_busy", 32'(busy), 0);

        // Accept on the final GUARD cycle
        s_data = 8'h3C; s_valid = 1'b1;
        tick();
        s_valid = 1'b0;
        for (int i = 1; i <= 6; i++) tick();
        check("lastg_state_e6", 32'(dbg_state), 32'(ST_GUARD));
        check("lastg_data_e6", 32'(sync_data), 32'h3C);
        s_data = 8'hC3; s_valid = 1'b1;
        tick();
        s_valid = 1'b0;
        check("lastg_data_e7", 32'(sync_data), 32'hC3);
        check("lastg_ready_e7", 32'(sync_ready), 1);
        check("lastg_state_e7", 32'(dbg_state), 32'(ST_HOLD));
        check("lastg_s_ready_e7", 32'(s_ready), 1);
        for (int i = 8; i <= 13; i++) tick();
        tick();
        check("lastg_idle_state", 32'(dbg_state), 32'(ST_IDLE));

        // Reset mid-HOLD
        s_data = 8'h77; s_valid = 1'b1;
        tick();
        s_valid = 1'b0;
        tick();
        tick();
        check("rhold_pre_ready", 32'(sync_ready), 1);
        #2 rstn = 1'b0;
        #1;
        check("rhold_ready", 32'(sync_ready), 0);
        check("rhold_data", 32'(sync_data), 0);
        check("rhold_busy", 32'(busy), 0);
        check("rhold_s_ready", 32'(s_ready), 1);
        check("rhold_state", 32'(dbg_state), 32'(ST_IDLE));
        #2 rstn = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("rhold_post_ready", 32'(sync_ready), 0);
            check("rhold_post_data", 32'(sync_data), 0);
            check("rhold_post_busy", 32'(busy), 0);
        end

        // Reset mid-GUARD with 0x5A pending
        s_data = 8'h12; s_valid = 1'b1;
        tick();
        s_data = 8'h5A;
        tick();
        s_valid = 1'b0;
        check("rpend_s_ready_full", 32'(s_ready), 0);
        for (int i = 2; i <= 5; i++) tick();
        check("rpend_state_guard", 32'(dbg_state), 32'(ST_GUARD));
        check("rpend_data_12", 32'(sync_data), 32'h12);
        #2 rstn = 1'b0;
        #1;
        check("rpend_s_ready", 32'(s_ready), 1);
        check("rpend_data", 32'(sync_data), 0);
        check("rpend_busy", 32'(busy), 0);
        #2 rstn = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            check("rpend_post_data", 32'(sync_data), 0);
            check("rpend_post_ready", 32'(sync_ready), 0);
            check("rpend_post_s_ready", 32'(s_ready), 1);
        end

        // End-to-end 0x00..0xFF
        for (int w = 0; w < 256; w++) begin
            e_s_data  = w[7:0];
            e_s_valid = 1'b1;
            got = 1'b0;
            for (int c = 0; c < 100 && !got; c++) begin
                if (e_s_ready) begin
                    exp_q.push_back(w[7:0]);
                    got = 1'b1;
                end
                tick();
            end
            if (!got) check("e2e_accept_timeout", 32'(w), 32'hFFFF_FFFF);
        end
        e_s_valid = 1'b0;
        for (int c = 0; c < 3000 && exp_q.size() != 0; c++) tick();
        repeat (20) tick();
        check("e2e_drain", 32'(exp_q.size()), 0);
        check("e2e_count", 32'(n_recv), 256);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
